prog_loader: RTL and testbench

Boot-time program loader for the 9-bit-instruction core. It accepts a byte stream over a valid/ready handshake and assembles two bytes into each 9-bit machine word. It writes each word into instruction memory at incrementing 12-bit addresses and holds the core in reset until the whole program is loaded. It is the write-side counterpart of the core's instruction fetch path.

---
 rtl/loader_pkg.sv | 23 ++
 rtl/prog_loader_if.sv | 30 +++
 rtl/prog_loader.sv | 108 ++++++++++
 tb/tb_prog_loader.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    INS_LO,
    INS_HI,
    WRITE,
    DONE,
    ERR
  } loader_state_t;

  localparam logic [7:0] LEN_HI_RSVD_MASK = 8'hF0;
  localparam logic [7:0] HI_RSVD_MASK     = 8'hFE;

  // States in which the loader consumes a stream byte.
  function automatic logic acceptsByte(input loader_state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == INS_LO) || (s == INS_HI);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface prog_loader_if #(
  parameter int D = 12,
  parameter int W = 9
) ();

  logic         start;
  logic [7:0]   inData;
  logic         inValid;
  logic         inReady;
  logic         imemWrEn;
  logic [D-1:0] imemAddr;
  logic [W-1:0] imemData;
  logic         coreReset;
  logic         loadDone;
  logic         error;

  // Host / boot source side.
  modport master (
    output start, inData, inValid,
    input  inReady, imemWrEn, imemAddr, imemData, coreReset, loadDone, error
  );

  // Loader side.
  modport slave (
    input  start, inData, inValid,
    output inReady, imemWrEn, imemAddr, imemData, coreReset, loadDone, error
  );

endinterface

// File: rtl/prog_loader.sv
// Assembles byte pairs into 9-bit words, writes them to instruction memory
// at incrementing addresses and holds the core in reset until loading ends.
module prog_loader
  import loader_pkg::*;
#(
  parameter int D = 12,
  parameter int W = 9
) (
  input  logic          clk,
  input  logic          reset,
  prog_loader_if.slave  bus
);

  loader_state_t state, nextState;

  logic [D-1:0] lenQ;
  logic [7:0]   lowQ;
  logic [D-1:0] addrQ;
  logic [W-1:0] dataQ;
  logic         inReadyQ;
  logic         wrEnQ;
  logic         coreResetQ;
  logic         loadDoneQ;
  logic         errorQ;

  logic xfer;
  logic restart;

  assign xfer    = bus.inValid && inReadyQ;
  assign restart = bus.start && ((state == IDLE) || (state == DONE) || (state == ERR));

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:   if (bus.start) nextState = LEN_LO;
      LEN_LO: if (xfer) nextState = LEN_HI;
      LEN_HI: begin
        if (xfer) begin
          if ((bus.inData & LEN_HI_RSVD_MASK) != 8'h00)
            nextState = ERR;
          else if ({bus.inData[3:0], lenQ[7:0]} == 12'd0)
            nextState = DONE;
          else
            nextState = INS_LO;
        end
      end
      INS_LO: if (xfer) nextState = INS_HI;
      INS_HI: begin
        if (xfer) begin
          if ((bus.inData & HI_RSVD_MASK) != 8'h00)
            nextState = ERR;
          else
            nextState = WRITE;
        end
      end
      WRITE:  nextState = (addrQ == lenQ - D'(1)) ? DONE : INS_LO;
      DONE:   if (bus.start) nextState = LEN_LO;
      ERR:    if (bus.start) nextState = LEN_LO;
      default: nextState = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addrQ      <= '0;
      dataQ      <= '0;
      inReadyQ   <= 1'b0;
      wrEnQ      <= 1'b0;
      coreResetQ <= 1'b1;
      loadDoneQ  <= 1'b0;
      errorQ     <= 1'b0;
    end else begin
      state      <= nextState;
      inReadyQ   <= acceptsByte(nextState);
      wrEnQ      <= (nextState == WRITE);
      coreResetQ <= (nextState != DONE);
      loadDoneQ  <= (nextState == DONE);
      errorQ     <= (nextState == ERR);
      if (restart)
        addrQ <= '0;
      else if ((state == WRITE) && (nextState == INS_LO))
        addrQ <= addrQ + D'(1);
      if ((state == INS_HI) && (nextState == WRITE))
        dataQ <= W'({bus.inData[0], lowQ});
    end
  end

  // Length and low-byte holding registers need no reset.
  always_ff @(posedge clk) begin
    if ((state == LEN_LO) && xfer)
      lenQ[7:0] <= bus.inData;
    if ((state == LEN_HI) && xfer)
      lenQ <= D'({bus.inData[3:0], lenQ[7:0]});
    if ((state == INS_LO) && xfer)
      lowQ <= bus.inData;
  end

  assign bus.inReady   = inReadyQ;
  assign bus.imemWrEn  = wrEnQ;
  assign bus.imemAddr  = addrQ;
  assign bus.imemData  = dataQ;
  assign bus.coreReset = coreResetQ;
  assign bus.loadDone  = loadDoneQ;
  assign bus.error     = errorQ;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: normal, empty, malformed, stalled and
// interrupted load sessions against a small instruction-memory model.
module tb_prog_loader;

  logic clk = 1'b0;
  logic reset = 1'b0;

  prog_loader_if #(.D(12), .W(9)) bus ();

  prog_loader #(.D(12), .W(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int writeCount = 0;
  logic [8:0] mem [0:4095];

  always @(negedge clk) begin
    if (bus.imemWrEn) begin
      mem[bus.imemAddr] = bus.imemData;
      writeCount = writeCount + 1;
    end
  end

  task automatic checkVal(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic sendByte(input logic [7:0] b);
    int n = 0;
    bus.inData  = b;
    bus.inValid = 1'b1;
    while (!bus.inReady && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkVal("inReady timeout", 0, 1);
    @(negedge clk);
    bus.inValid = 1'b0;
  endtask

  task automatic sendStalled(input logic [7:0] b);
    int gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) @(negedge clk);
    sendByte(b);
  endtask

  task automatic pulseStart();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkVal({tag, " inReady"},   int'(bus.inReady),   0);
    checkVal({tag, " imemWrEn"},  int'(bus.imemWrEn),  0);
    checkVal({tag, " imemAddr"},  int'(bus.imemAddr),  0);
    checkVal({tag, " imemData"},  int'(bus.imemData),  0);
    checkVal({tag, " coreReset"}, int'(bus.coreReset), 1);
    checkVal({tag, " loadDone"},  int'(bus.loadDone),  0);
    checkVal({tag, " error"},     int'(bus.error),     0);
  endtask

  logic [8:0] bpWords [4];

  initial begin
    bus.start   = 1'b0;
    bus.inData  = 8'h00;
    bus.inValid = 1'b0;
    bpWords[0] = 9'h0AB; bpWords[1] = 9'h155; bpWords[2] = 9'h1C3; bpWords[3] = 9'h001;

    repeat (2) @(negedge clk);
    checkResetValues("reset");
    reset = 1'b1;
    @(negedge clk);

    // Three-word load; start in IDLE together with a valid byte consumes nothing.
    bus.inData = 8'h55; bus.inValid = 1'b1;
    pulseStart();
    bus.inValid = 1'b0;
    checkVal("start inReady", int'(bus.inReady), 1);
    sendByte(8'h03); sendByte(8'h00);
    sendByte(8'hFF); sendByte(8'h01);
    sendByte(8'h00); sendByte(8'h00);
    sendByte(8'h7F); sendByte(8'h01);
    checkVal("w3 wrEn", int'(bus.imemWrEn), 1);
    checkVal("w3 addr", int'(bus.imemAddr), 2);
    checkVal("w3 still reset", int'(bus.coreReset), 1);
    checkVal("w3 not done", int'(bus.loadDone), 0);
    @(negedge clk);
    checkVal("w3 wrEn low", int'(bus.imemWrEn), 0);
    checkVal("3w loadDone", int'(bus.loadDone), 1);
    checkVal("3w coreReset", int'(bus.coreReset), 0);
    checkVal("3w count", writeCount, 3);
    checkVal("mem0", int'(mem[0]), 'h1FF);
    checkVal("mem1", int'(mem[1]), 'h000);
    checkVal("mem2", int'(mem[2]), 'h17F);

    // Zero length, restarted from DONE.
    writeCount = 0;
    pulseStart();
    checkVal("restart loadDone", int'(bus.loadDone), 0);
    checkVal("restart coreReset", int'(bus.coreReset), 1);
    sendByte(8'h00); sendByte(8'h00);
    checkVal("zero loadDone", int'(bus.loadDone), 1);
    checkVal("zero coreReset", int'(bus.coreReset), 0);
    checkVal("zero count", writeCount, 0);

    // Bad HI byte.
    pulseStart();
    sendByte(8'h01); sendByte(8'h00);
    sendByte(8'h12); sendByte(8'h02);
    checkVal("badhi error", int'(bus.error), 1);
    checkVal("badhi coreReset", int'(bus.coreReset), 1);
    checkVal("badhi inReady", int'(bus.inReady), 0);
    repeat (2) @(negedge clk);
    checkVal("badhi count", writeCount, 0);
    pulseStart();
    checkVal("err cleared", int'(bus.error), 0);
    checkVal("err restart inReady", int'(bus.inReady), 1);

    // Bad length: LEN_HI = 0x10.
    sendByte(8'h01); sendByte(8'h10);
    checkVal("badlen error", int'(bus.error), 1);
    checkVal("badlen inReady", int'(bus.inReady), 0);
    checkVal("badlen count", writeCount, 0);

    // Stalls, held valid through WRITE, ignored mid-session start.
    pulseStart();
    sendStalled(8'h04); sendStalled(8'h00);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        pulseStart();
        checkVal("midstart inReady", int'(bus.inReady), 1);
        checkVal("midstart addr", int'(bus.imemAddr), 2);
      end
      sendStalled(bpWords[i][7:0]);
      sendStalled({7'd0, bpWords[i][8]});
    end
    @(negedge clk);
    checkVal("bp loadDone", int'(bus.loadDone), 1);
    checkVal("bp count", writeCount, 4);
    for (int i = 0; i < 4; i++)
      checkVal($sformatf("bp mem%0d", i), int'(mem[i]), int'(bpWords[i]));

    // Reset mid-stream, after two of three words.
    writeCount = 0;
    pulseStart();
    sendByte(8'h03); sendByte(8'h00);
    sendByte(8'h11); sendByte(8'h00);
    sendByte(8'h22); sendByte(8'h01);
    @(negedge clk);
    bus.inData = 8'h33; bus.inValid = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    checkResetValues("midreset");
    checkVal("midreset count", writeCount, 2);
    bus.inValid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    writeCount = 0;
    pulseStart();
    sendByte(8'h01); sendByte(8'h00);
    sendByte(8'hF0); sendByte(8'h00);
    checkVal("rerun addr", int'(bus.imemAddr), 0);
    @(negedge clk);
    checkVal("rerun mem0", int'(mem[0]), 'h0F0);
    checkVal("rerun count", writeCount, 1);
    checkVal("rerun loadDone", int'(bus.loadDone), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
